fetch_unit: RTL and testbench

Instruction fetch stage feeding the F-to-D pipeline register. Owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, buffers returned instructions with their PC and PC+4, and presents them to decode. It takes stall and redirect (branch/jump target, flush) back from the decode/execute side, so it is the producing end of the pc/instr/pc_plus4 interface that decode consumes.

---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave):
// request/grant address phase plus in-order response phase.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_gnt;
  logic                  imem_rvalid;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem reads, buffers responses for decode.
// Define FETCH_ALIGN_CHECK_EN to turn a misaligned redirect into a sticky fault that halts fetching.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}},
  parameter int                    DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_unit_if.master          imem,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o
);
  localparam int                    AW         = $clog2(DEPTH);
  localparam int                    CW         = AW + 1;
  localparam logic [CW:0]           DEPTH_C    = (CW + 1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(DATA_WIDTH'(3));
  localparam logic [DATA_WIDTH-1:0] WORD_STEP  = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  logic [CW-1:0]         out_q, out_d, drop_q, drop_d, occ_q, occ_d;
  logic [AW-1:0]         fwr_q, fwr_d, frd_q, frd_d, iwr_q, iwr_d, ird_q, ird_d;
  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] ifl_mem_q   [DEPTH];

  logic        fault_s;
  logic [CW:0] credit_s;
  logic        req_s, issue_s, resp_s, drop_resp_s, push_s, pop_s, valid_s;

  // Outstanding requests plus buffered entries never exceed DEPTH, so a response always has a slot.
  assign credit_s    = {1'b0, out_q} + {1'b0, occ_q};
  assign valid_s     = (occ_q != {CW{1'b0}});
  assign req_s       = rst_n & ~redirect_i & ~fault_s & (credit_s < DEPTH_C);
  assign issue_s     = req_s & imem.imem_gnt;
  assign resp_s      = imem.imem_rvalid & (out_q != {CW{1'b0}});
  assign drop_resp_s = resp_s & (drop_q != {CW{1'b0}});
  assign push_s      = resp_s & ~drop_resp_s & ~redirect_i;
  assign pop_s       = valid_s & ~stall_i & ~redirect_i;

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = fpc_q;
  assign valid_o        = valid_s;
  assign instr_o        = instr_mem_q[frd_q];
  assign pc_o           = pc_mem_q[frd_q];
  assign pc_plus4_o     = pc_mem_q[frd_q] + WORD_STEP;

  // Next-state for PC, credit counters and both queue pointer pairs.
  always_comb begin
    fpc_d  = fpc_q;
    drop_d = drop_q;
    occ_d  = occ_q;
    fwr_d  = fwr_q;
    frd_d  = frd_q;
    iwr_d  = iwr_q;
    ird_d  = ird_q;
    case ({issue_s, resp_s})
      2'b10:   out_d = out_q + CW'(1);
      2'b01:   out_d = out_q - CW'(1);
      default: out_d = out_q;
    endcase
    if (redirect_i) begin
      // Every request still outstanding after this cycle belongs to the old path.
      fpc_d  = redirect_pc_i & ALIGN_MASK;
      drop_d = out_d;
      occ_d  = {CW{1'b0}};
      fwr_d  = {AW{1'b0}};
      frd_d  = {AW{1'b0}};
      iwr_d  = {AW{1'b0}};
      ird_d  = {AW{1'b0}};
    end else begin
      if (issue_s) begin
        fpc_d = fpc_q + WORD_STEP;
      end else begin
        fpc_d = fpc_q;
      end
      if (drop_resp_s) begin
        drop_d = drop_q - CW'(1);
      end else begin
        drop_d = drop_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
      fwr_d = fwr_q + AW'(push_s);
      frd_d = frd_q + AW'(pop_s);
      iwr_d = iwr_q + AW'(issue_s);
      ird_d = ird_q + AW'(resp_s & ~drop_resp_s);
    end
  end

  // State and queue storage; in-flight PCs are consumed only by responses that are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q  <= RESET_PC;
      out_q  <= {CW{1'b0}};
      drop_q <= {CW{1'b0}};
      occ_q  <= {CW{1'b0}};
      fwr_q  <= {AW{1'b0}};
      frd_q  <= {AW{1'b0}};
      iwr_q  <= {AW{1'b0}};
      ird_q  <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= {DATA_WIDTH{1'b0}};
        pc_mem_q[i]    <= {DATA_WIDTH{1'b0}};
        ifl_mem_q[i]   <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      fpc_q  <= fpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      occ_q  <= occ_d;
      fwr_q  <= fwr_d;
      frd_q  <= frd_d;
      iwr_q  <= iwr_d;
      ird_q  <= ird_d;
      if (push_s) begin
        instr_mem_q[fwr_q] <= imem.imem_rdata;
        pc_mem_q[fwr_q]    <= ifl_mem_q[ird_q];
      end
      if (issue_s) begin
        ifl_mem_q[iwr_q] <= fpc_q;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  // A misaligned redirect latches the fault until reset.
  always_comb begin
    if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
      fault_d = 1'b1;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_s = fault_q;
`else
  assign fault_s = 1'b0;
`endif

  assign fault_o = fault_s;
endmodule

// File: tb/tb_fetch_unit.sv
// Random-timing bench for fetch_unit: memory, stalls and redirects driven with $urandom and compared
// each cycle against a queue model of requests in flight and instructions awaiting decode.
module tb_fetch_unit;
  localparam int            DW       = 32;
  localparam int            DEPTH    = 4;
  localparam logic [DW-1:0] RESET_PC = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          stall_i;
  logic          redirect_i;
  logic [DW-1:0] redirect_pc_i;
  logic          valid_o;
  logic [DW-1:0] instr_o;
  logic [DW-1:0] pc_o;
  logic [DW-1:0] pc_plus4_o;
  logic          fault_o;

  fetch_unit_if #(.DATA_WIDTH(DW)) bus ();

  fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_tests;
  int            n_fail;
  int            cyc;
  int            consumed;
  int            drop_cnt;
  logic [DW-1:0] exp_fetch;
  logic          exp_fault;
  logic [DW-1:0] pend_addr [$];
  int            pend_rdy  [$];
  logic [DW-1:0] exp_q     [$];

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, check and advance the model before the next edge.
  task automatic tick(input logic st, input logic rd, input logic [DW-1:0] rpc,
                      input int gpct, input int lat, input int rvpct);
    logic          exp_req;
    logic [DW-1:0] a;
    @(posedge clk);
    #1;
    cyc++;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    bus.imem_gnt  = (int'($urandom_range(99)) < gpct);
    if (pend_addr.size() > 0 && pend_rdy[0] <= cyc && int'($urandom_range(99)) < rvpct) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend_addr[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
    @(negedge clk);
    exp_req = !rd && !exp_fault && (pend_addr.size() + exp_q.size() < DEPTH);
    check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) check_eq("imem_addr", bus.imem_addr, exp_fetch);
    check_eq("valid", 32'(valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("pc", pc_o, exp_q[0]);
      check_eq("instr", instr_o, mem_word(exp_q[0]));
      check_eq("pc_plus4", pc_plus4_o, exp_q[0] + 32'd4);
    end
    check_eq("fault", 32'(fault_o), 32'(exp_fault));
    if (exp_q.size() != 0 && !st && !rd) begin
      void'(exp_q.pop_front());
      consumed++;
    end
    if (bus.imem_rvalid) begin
      a = pend_addr.pop_front();
      void'(pend_rdy.pop_front());
      if (drop_cnt > 0) drop_cnt--;
      else if (!rd) exp_q.push_back(a);
    end
    if (exp_req && bus.imem_gnt) begin
      pend_addr.push_back(exp_fetch);
      pend_rdy.push_back(cyc + 1 + lat);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (rd) begin
      exp_q.delete();
      drop_cnt  = pend_addr.size();
      exp_fetch = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) exp_fault = 1'b1;
`endif
    end
  endtask

  // Asynchronous reset away from the clock edge, then a stray response with nothing outstanding.
  task automatic do_reset();
    #1;
    rst_n           = 1'b0;
    stall_i         = 1'b0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'h0000_0000;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0000_0000;
    #1;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", bus.imem_addr, RESET_PC);
    check_eq("rst_fault", 32'(fault_o), 32'd0);
    pend_addr.delete();
    pend_rdy.delete();
    exp_q.delete();
    drop_cnt  = 0;
    exp_fetch = RESET_PC;
    exp_fault = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    #1;
    check_eq("rst_req_first", 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    consumed = 0;
    rst_n    = 1'b1;
    do_reset();

    repeat (20) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);
    repeat (6)  tick(1'b1, 1'b0, 32'h0, 100, 0, 100);
    repeat (8)  tick(1'b0, 1'b0, 32'h0, 100, 0, 100);

    repeat (3)  tick(1'b0, 1'b0, 32'h0, 0, 0, 100);
    repeat (12) tick(1'b0, 1'b0, 32'h0, 100, 2, 100);

    for (int k = 0; k < 20 && pend_addr.size() != 3; k++) tick(1'b0, 1'b0, 32'h0, 100, 2, 100);
    check_eq("inflight3", 32'(pend_addr.size()), 32'd3);
    tick(1'b0, 1'b1, 32'h0000_0100, 100, 2, 100);
    repeat (10) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);

    repeat (5) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);
    tick(1'b1, 1'b1, 32'h0000_0200, 100, 0, 100);
    check_eq("same_cycle_rvalid", 32'(bus.imem_rvalid), 32'd1);
    repeat (6) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);

    tick(1'b0, 1'b1, 32'hFFFF_FFF8, 100, 0, 100);
    repeat (10) tick(1'b0, 1'b0, 32'h0, 100, 1, 100);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      tick(int'($urandom_range(99)) < 20, int'($urandom_range(99)) < 3,
           $urandom & 32'h0000_3FFC, int'($urandom_range(100, 50)),
           int'($urandom_range(3)), int'($urandom_range(100, 40)));
    end

    repeat (4) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);
    tick(1'b0, 1'b1, 32'h0000_0102, 100, 0, 100);
    repeat (10) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);
    do_reset();
    repeat (6) tick(1'b0, 1'b0, 32'h0, 100, 0, 100);

    check_eq("progress", 32'(consumed > 600), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
